// File: rtl/collector_pkg.sv
// Shared types and constants for the serial byte collector and the detector that follows it.
package collector_pkg;
    localparam int WORD_W = 8;
    localparam int CNT_W  = 16;

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;
endpackage

// File: rtl/serial_byte_collector_if.sv
// Serial-in / word-out handshake bundle between a bit source, the collector and its word consumer.
interface serial_byte_collector_if
    import collector_pkg::*;
#(
    parameter int W = WORD_W
);
    logic             in_bit;
    logic             in_valid;
    logic             in_ready;
    logic             frame_clr;
    logic [W-1:0]     data_out;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] word_cnt;

    // The environment drives the serial side and consumes words.
    modport master (
        output in_bit, in_valid, frame_clr, out_ready,
        input  in_ready, data_out, out_valid, word_cnt
    );

    modport slave (
        input  in_bit, in_valid, frame_clr, out_ready,
        output in_ready, data_out, out_valid, word_cnt
    );
endinterface

// File: rtl/serial_byte_collector.sv
// Assembles a valid/ready serial bit stream MSB-first into W-bit words, with a one-word stall buffer
// so a new word can complete while the consumer still holds the previous one.
module serial_byte_collector
    import collector_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_byte_collector_if.slave  bus
);
    localparam int BW = $clog2(W);

    state_t        state;
    logic [W-1:0]  shift_reg;
    logic [BW-1:0] bit_cnt;
    logic [W-1:0]  word;
    logic          accept;
    logic          handshake;
    logic          last_bit;

    assign word      = {shift_reg[W-2:0], bus.in_bit};
    assign accept    = bus.in_valid && bus.in_ready;
    assign handshake = bus.out_valid && bus.out_ready;
    assign last_bit  = (bit_cnt == BW'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= COLLECT;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
            bus.word_cnt  <= '0;
            shift_reg     <= '0;
            bit_cnt       <= '0;
        end else begin
            // A consumed word empties the slot unless something reloads it below.
            if (handshake) begin
                bus.word_cnt  <= bus.word_cnt + CNT_W'(1);
                bus.out_valid <= 1'b0;
            end

            case (state)
                COLLECT: begin
                    if (bus.frame_clr) begin
                        // Discards the partial word, including a bit accepted this same cycle.
                        bit_cnt <= '0;
                    end else if (accept) begin
                        shift_reg <= word;
                        if (last_bit) begin
                            bit_cnt <= '0;
                            if (!bus.out_valid || bus.out_ready) begin
                                bus.data_out  <= word;
                                bus.out_valid <= 1'b1;
                            end else begin
                                state        <= STALL;
                                bus.in_ready <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end

                STALL: begin
                    // The slot is always occupied here, so out_ready alone means a handshake.
                    if (bus.out_ready) begin
                        bus.data_out  <= shift_reg;
                        bus.out_valid <= 1'b1;
                        state         <= COLLECT;
                        bus.in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state        <= COLLECT;
                    bus.in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_byte_collector.sv
// Directed and random stimulus for serial_byte_collector with a word scoreboard checked at each out handshake.
module tb_serial_byte_collector;
    import collector_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   rand_rdy = 1'b0;

    int vectors = 0;
    int errors  = 0;
    logic [7:0] sb_q[$];

    serial_byte_collector_if #(.W(WORD_W)) bus_i ();

    serial_byte_collector #(.W(WORD_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every out handshake must match the oldest word still expected.
    always @(negedge clk) begin
        if (!rst && bus_i.out_valid === 1'b1 && bus_i.out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                vectors++;
                errors++;
                $error("FAIL sb_unexpected observed=0x%0h expected=none", bus_i.data_out);
            end else begin
                chk("sb_word", bus_i.data_out, sb_q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) bus_i.out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send_bit(input logic b, input logic clr);
        int n = 0;
        bus_i.in_valid  = 1'b1;
        bus_i.in_bit    = b;
        bus_i.frame_clr = clr;
        do begin
            @(negedge clk);
            n++;
        end while (bus_i.in_ready !== 1'b1 && n < 300);
        if (bus_i.in_ready !== 1'b1) chk("in_ready_timeout", {31'b0, bus_i.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus_i.in_valid  = 1'b0;
        bus_i.frame_clr = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input bit push);
        if (push) sb_q.push_back(w);
        for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        bus_i.in_bit    = 1'b1;
        bus_i.in_valid  = 1'b1;
        bus_i.frame_clr = 1'b0;
        bus_i.out_ready = 1'b1;

        // Reset held for two cycles with in_valid high.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_in_ready",  {31'b0, bus_i.in_ready},  32'd1);
            chk("rst_out_valid", {31'b0, bus_i.out_valid}, 32'd0);
            chk("rst_data_out",  {24'b0, bus_i.data_out},  32'h00);
            chk("rst_word_cnt",  {16'b0, bus_i.word_cnt},  32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_i.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_no_word", {31'b0, bus_i.out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Single word with the consumer always ready: one-cycle valid pulse.
        send_word(8'hE1, 1'b1);
        @(negedge clk);
        chk("single_valid", {31'b0, bus_i.out_valid}, 32'd1);
        chk("single_data",  {24'b0, bus_i.data_out},  32'hE1);
        cycles(1);
        @(negedge clk);
        chk("single_pulse_end", {31'b0, bus_i.out_valid}, 32'd0);
        chk("single_cnt",       {16'b0, bus_i.word_cnt},  32'd1);

        // Back-pressure: second word parks, serial side stalls.
        do_reset();
        bus_i.out_ready = 1'b0;
        send_word(8'hA5, 1'b1);
        send_word(8'h3C, 1'b1);
        @(negedge clk);
        chk("bp_in_ready", {31'b0, bus_i.in_ready}, 32'd0);
        chk("bp_data",     {24'b0, bus_i.data_out}, 32'hA5);
        cycles(3);
        @(negedge clk);
        chk("bp_hold_data",  {24'b0, bus_i.data_out},  32'hA5);
        chk("bp_hold_valid", {31'b0, bus_i.out_valid}, 32'd1);
        chk("bp_hold_ready", {31'b0, bus_i.in_ready},  32'd0);
        @(posedge clk);
        #1;
        bus_i.out_ready = 1'b1;
        cycles(1);
        bus_i.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_exit_data",  {24'b0, bus_i.data_out},  32'h3C);
        chk("bp_exit_valid", {31'b0, bus_i.out_valid}, 32'd1);
        chk("bp_exit_ready", {31'b0, bus_i.in_ready},  32'd1);
        chk("bp_exit_cnt",   {16'b0, bus_i.word_cnt},  32'd1);
        @(posedge clk);
        #1;
        bus_i.out_ready = 1'b1;
        cycles(2);
        @(negedge clk);
        chk("bp_drain_cnt", {16'b0, bus_i.word_cnt}, 32'd2);

        // Frame clear: partial word discarded, next word intact.
        do_reset();
        bus_i.out_ready = 1'b1;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        bus_i.frame_clr = 1'b1;
        cycles(1);
        bus_i.frame_clr = 1'b0;
        send_word(8'h0F, 1'b1);
        @(negedge clk);
        chk("fc_data",  {24'b0, bus_i.data_out},  32'h0F);
        chk("fc_valid", {31'b0, bus_i.out_valid}, 32'd1);
        cycles(1);
        // Clear on the eighth bit wins: no word appears.
        for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("fc8_no_word", {31'b0, bus_i.out_valid}, 32'd0);
        end
        chk("fc8_cnt", {16'b0, bus_i.word_cnt}, 32'd1);
        @(posedge clk);
        #1;
        send_word(8'h5A, 1'b1);
        @(negedge clk);
        chk("fc_after_data", {24'b0, bus_i.data_out}, 32'h5A);

        // Continuous random stream with a randomly stalling consumer.
        cycles(1);
        do_reset();
        rand_rdy = 1'b1;
        for (int w = 0; w < 64; w++) send_word(8'($urandom_range(0, 255)), 1'b1);
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        bus_i.out_ready = 1'b1;
        for (int c = 0; c < 20 && sb_q.size() != 0; c++) cycles(1);
        cycles(2);
        @(negedge clk);
        chk("rand_left",  sb_q.size(), 32'd0);
        chk("rand_cnt",   {16'b0, bus_i.word_cnt},  32'd64);
        chk("rand_valid", {31'b0, bus_i.out_valid}, 32'd0);

        // Reset while one word is parked and one is in the output slot.
        @(posedge clk);
        #1;
        bus_i.out_ready = 1'b0;
        send_word(8'h12, 1'b1);
        send_word(8'h34, 1'b1);
        @(negedge clk);
        chk("rs_stalled", {31'b0, bus_i.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        chk("rs_out_valid", {31'b0, bus_i.out_valid}, 32'd0);
        chk("rs_in_ready",  {31'b0, bus_i.in_ready},  32'd1);
        chk("rs_cnt",       {16'b0, bus_i.word_cnt},  32'd0);
        @(posedge clk);
        #1;
        bus_i.out_ready = 1'b1;
        send_word(8'hFF, 1'b1);
        @(negedge clk);
        chk("rs_data",  {24'b0, bus_i.data_out},  32'hFF);
        chk("rs_valid", {31'b0, bus_i.out_valid}, 32'd1);
        cycles(2);
        chk("rs_sb_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
